// File: rtl/nano_boot_loader.sv
// Boot loader: clears program memory, streams a program into it, then
// releases the CPU from reset and hands it the memory bus.
module nano_boot_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              start_load,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_dataW,
  input  logic              cpu_ce,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_dataR,
  output logic              cpu_rst,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] dataW,
  output logic              ce,
  output logic              we,
  input  logic [DATA_W-1:0] dataR,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned       PTR_W    = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RELEASE,
    S_RUN
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] wcnt_q, wcnt_d;
  logic             ovf_q, ovf_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             at_top;

  assign at_top = (ptr_q[ADDR_W-1:0] == TOP_ADDR);

  // State and bookkeeping registers
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      wcnt_q    <= '0;
      ovf_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wcnt_q    <= wcnt_d;
      ovf_q     <= ovf_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  // Next-state logic and memory bus steering
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wcnt_d    = wcnt_q;
    ovf_d     = ovf_q;
    address   = '0;
    dataW     = '0;
    ce        = 1'b0;
    we        = 1'b0;
    in_ready  = 1'b0;
    cpu_dataR = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start_load) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
          wcnt_d  = '0;
          ovf_d   = 1'b0;
        end
      end

      S_CLEAR: begin
        ce      = 1'b1;
        we      = 1'b1;
        address = ptr_q[ADDR_W-1:0];
        ptr_d   = ptr_q + PTR_W'(1);
        if (at_top) begin
          state_d = S_LOAD;
          ptr_d   = '0;
        end
      end

      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ce      = 1'b1;
          we      = 1'b1;
          address = ptr_q[ADDR_W-1:0];
          dataW   = in_data;
          ptr_d   = ptr_q + PTR_W'(1);
          wcnt_d  = wcnt_q + PTR_W'(1);
          if (in_last || at_top) begin
            state_d = S_RELEASE;
          end
          // Memory full before the stream ended: the remainder is dropped
          if (at_top && !in_last) begin
            ovf_d = 1'b1;
          end
        end
      end

      S_RELEASE: begin
        state_d = S_RUN;
      end

      S_RUN: begin
        address   = cpu_address;
        dataW     = cpu_dataW;
        ce        = cpu_ce;
        we        = cpu_we;
        cpu_dataR = dataR;
        if (start_load) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
          wcnt_d  = '0;
          ovf_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    cpu_rst_d = (state_d != S_RUN);
  end

  assign cpu_rst    = cpu_rst_q;
  assign busy       = (state_q == S_CLEAR) || (state_q == S_LOAD);
  assign done       = (state_q == S_RUN);
  assign overflow   = ovf_q;
  assign word_count = wcnt_q;

endmodule

// File: tb/tb_nano_boot_loader.sv
// Directed bench for nano_boot_loader with a behavioural 256x16 memory.
module tb_nano_boot_loader;

  logic        ck;
  logic        rst;
  logic        start_load;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic [7:0]  cpu_address;
  logic [15:0] cpu_dataW;
  logic        cpu_ce;
  logic        cpu_we;
  logic [15:0] cpu_dataR;
  logic        cpu_rst;
  logic [7:0]  address;
  logic [15:0] dataW;
  logic        ce;
  logic        we;
  logic [15:0] dataR;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [8:0]  word_count;

  nano_boot_loader dut (
    .ck          (ck),
    .rst         (rst),
    .start_load  (start_load),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .cpu_address (cpu_address),
    .cpu_dataW   (cpu_dataW),
    .cpu_ce      (cpu_ce),
    .cpu_we      (cpu_we),
    .cpu_dataR   (cpu_dataR),
    .cpu_rst     (cpu_rst),
    .address     (address),
    .dataW       (dataW),
    .ce          (ce),
    .we          (we),
    .dataR       (dataR),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .word_count  (word_count)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Memory model plus a log of every write seen on the bus
  logic [15:0] mem [256];
  int          wr_cnt;
  logic [7:0]  wr_last_addr;
  logic [7:0]  wr_prev_addr;

  assign dataR = mem[address];

  always @(posedge ck) begin
    if (ce && we) begin
      mem[address] = dataW;
      wr_prev_addr = wr_last_addr;
      wr_last_addr = address;
      wr_cnt       = wr_cnt + 1;
    end
  end

  int n_vec;
  int n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ck);
    @(negedge ck);
  endtask

  // Walks the 256 clear cycles; start_load pulsed midway must be ignored
  task automatic run_clear(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      start_load = (i == 100);
      #1;
      if (!(ce && we && busy && cpu_rst && !done && !in_ready &&
            address == 8'(i) && dataW == 16'h0000)) bad++;
      step();
    end
    start_load = 1'b0;
    check({tag, "_clear_seq"}, 32'(bad), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [15:0] wd;
    logic        c;
    logic        w;
    logic [15:0] exp_r;
  } vec_t;

  vec_t vt [6];

  initial begin
    int nz;
    int bad;
    int wr0;
    logic [15:0] words [3];
    logic        bp_valid [4];
    logic        bp_last  [4];

    vt[0] = '{8'h00, 16'h0000, 1'b1, 1'b0, 16'h4000};
    vt[1] = '{8'h02, 16'h0000, 1'b1, 1'b0, 16'h4222};
    vt[2] = '{8'h0A, 16'h0037, 1'b1, 1'b1, 16'h0000};
    vt[3] = '{8'h0A, 16'h0000, 1'b1, 1'b0, 16'h0037};
    vt[4] = '{8'h03, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
    vt[5] = '{8'h01, 16'h0000, 1'b1, 1'b0, 16'h4111};
    words[0] = 16'h4000; words[1] = 16'h4111; words[2] = 16'h4222;
    bp_valid[0] = 1'b1; bp_valid[1] = 1'b0; bp_valid[2] = 1'b0; bp_valid[3] = 1'b1;
    bp_last[0]  = 1'b0; bp_last[1]  = 1'b0; bp_last[2]  = 1'b0; bp_last[3]  = 1'b1;

    n_vec = 0; n_err = 0; wr_cnt = 0;
    wr_last_addr = '0; wr_prev_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;

    rst = 1'b0; start_load = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    cpu_address = '0; cpu_dataW = '0; cpu_ce = 1'b0; cpu_we = 1'b0;

    // Reset state
    @(negedge ck); #1;
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_ce_we", 32'({ce, we, in_ready}), 32'd0);
    check("rst_busy_done", 32'({busy, done, overflow}), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);

    // IDLE ignores the CPU bus
    rst = 1'b1;
    cpu_address = 8'h55; cpu_dataW = 16'h1234; cpu_ce = 1'b1; cpu_we = 1'b1;
    #1;
    check("idle_bus", 32'({ce, we, in_ready}), 32'd0);
    check("idle_cpu_dataR", 32'(cpu_dataR), 32'd0);
    check("idle_cpu_rst", 32'(cpu_rst), 32'd1);
    step();

    // Load a three-word program
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    run_clear("load");
    nz = 0;
    for (int i = 0; i < 256; i++) if (mem[i] != 16'h0000) nz++;
    check("load_mem_cleared", 32'(nz), 32'd0);
    cpu_ce = 1'b0; cpu_we = 1'b0;
    #1;
    check("load_idle_ready", 32'({in_ready, busy, we}), 32'b110);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = words[k]; in_last = (k == 2);
      #1;
      check("load_beat_we", 32'({ce, we}), 32'b11);
      check("load_beat_addr", 32'(address), 32'(k));
      check("load_beat_data", 32'(dataW), 32'(words[k]));
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    #1;
    check("rel_bus", 32'({ce, we, in_ready}), 32'd0);
    check("rel_flags", 32'({cpu_rst, busy, done}), 32'b100);
    check("rel_word_count", 32'(word_count), 32'd3);
    step();
    check("run_flags", 32'({cpu_rst, busy, done, overflow}), 32'b0010);
    check("run_mem0", 32'(mem[0]), 32'h4000);
    check("run_mem2", 32'(mem[2]), 32'h4222);
    check("run_mem3", 32'(mem[3]), 32'h0000);

    // CPU bus pass-through vectors
    for (int v = 0; v < 6; v++) begin
      cpu_address = vt[v].a; cpu_dataW = vt[v].wd; cpu_ce = vt[v].c; cpu_we = vt[v].w;
      #1;
      check("pt_address", 32'(address), 32'(vt[v].a));
      check("pt_dataW", 32'(dataW), 32'(vt[v].wd));
      check("pt_ce_we", 32'({ce, we}), 32'({vt[v].c, vt[v].w}));
      check("pt_cpu_dataR", 32'(cpu_dataR), 32'(vt[v].exp_r));
      step();
    end
    cpu_ce = 1'b0; cpu_we = 1'b0; cpu_address = '0; cpu_dataW = '0;

    // Reload with a backpressured stream
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    #1;
    check("reload1_flags", 32'({cpu_rst, busy, done}), 32'b110);
    check("reload1_addr", 32'(address), 32'd0);
    run_clear("bp");
    check("bp_mem_0a_cleared", 32'(mem[10]), 32'h0000);
    wr0 = wr_cnt;
    for (int k = 0; k < 4; k++) begin
      in_valid = bp_valid[k]; in_last = bp_last[k]; in_data = 16'h5000 + 16'(k / 3);
      #1;
      check("bp_we", 32'({ce, we}), 32'({bp_valid[k], bp_valid[k]}));
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("bp_write_count", 32'(wr_cnt - wr0), 32'd2);
    check("bp_write_addrs", 32'({wr_prev_addr, wr_last_addr}), 32'h0001);
    check("bp_word_count", 32'(word_count), 32'd2);
    check("bp_mem", 32'({mem[0], mem[1]}), 32'h50005001);
    step();

    // Overflow: 257 beats without in_last
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    run_clear("ovf");
    wr0 = wr_cnt;
    bad = 0;
    for (int k = 0; k < 257; k++) begin
      in_valid = 1'b1; in_data = 16'h6000 + 16'(k);
      #1;
      if (k < 256) begin
        if (!(in_ready && we && ce && !overflow && address == 8'(k))) bad++;
      end else begin
        check("ovf_ready_dropped", 32'({in_ready, ce, we}), 32'd0);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_word_count", 32'(word_count), 32'd256);
      end
      step();
    end
    in_valid = 1'b0;
    check("ovf_beats", 32'(bad), 32'd0);
    check("ovf_write_count", 32'(wr_cnt - wr0), 32'd256);
    check("ovf_mem_ends", 32'({mem[0], mem[255]}), 32'h600060FF);
    #1;
    check("ovf_run", 32'({cpu_rst, done, overflow}), 32'b011);

    // Reload from RUN clears overflow; then reset in the middle of LOAD
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    #1;
    check("reload2_flags", 32'({cpu_rst, busy, done, overflow}), 32'b1100);
    check("reload2_addr_wc", 32'({address, word_count}), 32'd0);
    run_clear("abort");
    in_valid = 1'b1; in_data = 16'h7777;
    #1;
    check("abort_pre_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_bus", 32'({ce, we, in_ready}), 32'd0);
    check("abort_cpu_rst", 32'(cpu_rst), 32'd1);
    step();
    rst = 1'b1; in_valid = 1'b0;
    #1;
    check("abort_idle", 32'({busy, done, overflow, in_ready}), 32'd0);
    check("abort_word_count", 32'(word_count), 32'd0);
    check("abort_mem0", 32'(mem[0]), 32'h0000);
    step();

    // Single-word program after a long idle stretch in LOAD
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    run_clear("empty");
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (!(in_ready && busy && !we)) bad++;
      step();
    end
    check("empty_wait", 32'(bad), 32'd0);
    in_valid = 1'b1; in_last = 1'b1; in_data = 16'h0ABC;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    #1;
    check("empty_word_count", 32'(word_count), 32'd1);
    step();
    check("empty_run", 32'({cpu_rst, done}), 32'b01);
    check("empty_mem", 32'({mem[0], mem[1]}), 32'h0ABC0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nano_boot_loader.md
NANO_BOOT_LOADER -- requirements
Module: nano_boot_loader

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width (256 words).
REQ-002 Parameter DATA_W, default 16, memory word width.
REQ-003 Port ck  input  1  single clock; all state on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-005 Port start_load  input  1  single-cycle request to (re)load program memory.
REQ-006 Port in_valid / in_ready  input / output  1 / 1  program word stream handshake; transfer when both high on a rising edge.
REQ-007 Port in_data  input  DATA_W  program word.
REQ-008 Port in_last  input  1  marks final word of the program.
REQ-009 Port cpu_address, cpu_dataW, cpu_ce, cpu_we  input  ADDR_W, DATA_W, 1, 1  CPU memory bus request.
REQ-010 Port cpu_dataR  output  DATA_W  read data returned to the CPU.
REQ-011 Port cpu_rst  output  1  active-high reset driven to the CPU.
REQ-012 Port address, dataW, ce, we  output  ADDR_W, DATA_W, 1, 1  memory bus; memory writes dataW at address on the rising edge when we=1.
REQ-013 Port dataR  input  DATA_W  combinational memory read data.
REQ-014 Port busy, done, overflow  output  1 each  status: clearing/loading, program running, load truncated.
REQ-015 Port word_count  output  ADDR_W+1  words accepted in the most recent load (0..256).

Function
REQ-016 States IDLE, CLEAR, LOAD, RELEASE, RUN; one state register, one pointer ptr of ADDR_W+1 bits.
REQ-017 IDLE: cpu_rst=1, ce=0, we=0, in_ready=0; start_load=1 -> CLEAR with ptr=0, overflow=0, word_count=0.
REQ-018 CLEAR: ce=1, we=1, address=ptr[ADDR_W-1:0], dataW=0 every cycle; ptr increments; after writing address 255 (256 cycles) -> LOAD with ptr=0.
REQ-019 LOAD: in_ready=1; on each transfer ce=1, we=1, address=ptr, dataW=in_data in that same cycle; ptr and word_count increment; no write on cycles without a transfer.
REQ-020 LOAD exit: transfer with in_last=1, or transfer at ptr=255 -> RELEASE next cycle; in_ready=0 from RELEASE onward.
REQ-021 Overflow: transfer at ptr=255 with in_last=0 sets overflow=1 (sticky until next start_load); further stream beats are not accepted.
REQ-022 RELEASE: one cycle, bus idle (ce=0, we=0), cpu_rst=1; then RUN.
REQ-023 RUN: cpu_rst=0 (registered, low from first RUN cycle); address=cpu_address, dataW=cpu_dataW, ce=cpu_ce, we=cpu_we, cpu_dataR=dataR, all combinational, zero added latency.
REQ-024 Outside RUN: cpu_dataR=0, CPU bus inputs ignored.
REQ-025 start_load ignored in CLEAR, LOAD, RELEASE; in RUN -> CLEAR next cycle with cpu_rst=1 in that CLEAR cycle.
REQ-026 busy=1 in CLEAR and LOAD; done=1 in RUN only; both registered-state decodes.
REQ-027 Empty program: in_last on first LOAD transfer -> word_count=1; in_valid never asserted -> remains in LOAD indefinitely.

Reset
REQ-028 rst=0 immediately forces IDLE, ptr=0, word_count=0, overflow=0, cpu_rst=1, we=0, ce=0, in_ready=0, busy=0, done=0, regardless of state or clock.
REQ-029 Reset mid-CLEAR or mid-LOAD aborts the operation; memory contents already written are not restored.

Verification
REQ-030 Reset: hold rst=0 in LOAD -> we=0, in_ready=0, cpu_rst=1 before next ck edge; after release state IDLE, word_count=0.
REQ-031 Load: start_load, then 0x4000, 0x4111, 0x4222 (in_last on third) -> 256 zero writes to 0..255, writes at 0,1,2, word_count=3, cpu_rst=0 two edges after third transfer, done=1.
REQ-032 Backpressure: in_valid toggled 1,0,0,1 during LOAD -> exactly two writes, addresses 0 and 1, no we on idle cycles.
REQ-033 Overflow: 257 beats, in_last never set -> 256 writes, in_ready=0 after 256th, overflow=1, word_count=256, RUN reached.
REQ-034 RUN pass-through: cpu_we=1, cpu_address=0x0A, cpu_dataW=0x0037 -> we=1, address=0x0A same cycle; next read of 0x0A returns cpu_dataR=0x0037.
REQ-035 Reload: start_load in RUN -> cpu_rst=1, done=0, busy=1 next cycle, CLEAR restarts at address 0, overflow cleared.
